// File: rtl/timer_pkg.sv
// timer_pkg: register map offsets, CTRL bit positions and reset constants for timer_irq
package timer_pkg;
  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRESC  = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_CMP    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_PERIODIC = 2;
  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides clk by PRESC+1 while enabled, pulsing tick_o on the last count
module timer_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               load_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  always_comb begin
    tick_o = en_i & (pcnt_q == presc_i);
    pcnt_d = load_i ? '0 : tick_o ? '0 : en_i ? pcnt_q + 1'b1 : pcnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) pcnt_q <= '0;
    else pcnt_q <= pcnt_d;
  end
endmodule

// File: rtl/timer_irq.sv
// timer_irq: memory-mapped prescaled timer with compare match and level interrupt
module timer_irq import timer_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int          PRESC_W   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  output logic [31:0] rdata_o,
  output logic        hit_o,
  output logic        irq_o
);
  logic [2:0]         ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [31:0]        count_q, count_d, cmp_q, cmp_d, rd, rdata_d;
  logic               pend_q, pend_d, irq_d;
  logic               hit, wr, ctrl_wr, presc_wr, count_wr, cmp_wr, status_wr, tick, match;
  logic [2:0]         off;
  logic               unused_lsb;
  assign unused_lsb = ^addr_i[1:0];
  timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (ctrl_q[CTRL_EN]),
    .load_i (ctrl_wr | presc_wr),
    .presc_i(presc_q),
    .tick_o (tick)
  );
  always_comb begin
    hit       = addr_i[31:5] == BASE_ADDR[31:5];
    off       = addr_i[4:2];
    wr        = hit & we_i;
    ctrl_wr   = wr & (off == OFF_CTRL);
    presc_wr  = wr & (off == OFF_PRESC);
    count_wr  = wr & (off == OFF_COUNT);
    cmp_wr    = wr & (off == OFF_CMP);
    status_wr = wr & (off == OFF_STATUS);
    ctrl_d    = ctrl_wr ? wdata_i[2:0] : ctrl_q;
    presc_d   = presc_wr ? wdata_i[PRESC_W-1:0] : presc_q;
    cmp_d     = cmp_wr ? wdata_i : cmp_q;
    // a software COUNT write overrides the tick, so no match can fire that cycle
    match     = tick & ~count_wr & (count_q == cmp_q);
    count_d   = count_wr ? wdata_i :
                (match & ctrl_q[CTRL_PERIODIC]) ? '0 :
                tick ? count_q + 1'b1 : count_q;
    pend_d    = match | (pend_q & ~(status_wr & wdata_i[0]));
    irq_d     = pend_q & ctrl_q[CTRL_IRQ_EN];
    rd        = (off == OFF_CTRL)   ? {29'd0, ctrl_q} :
                (off == OFF_PRESC)  ? {{(32-PRESC_W){1'b0}}, presc_q} :
                (off == OFF_COUNT)  ? count_q :
                (off == OFF_CMP)    ? cmp_q :
                (off == OFF_STATUS) ? {31'd0, pend_q} : '0;
    rdata_d   = hit ? rd : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q  <= '0;
      presc_q <= '0;
      count_q <= '0;
      cmp_q   <= CMP_RST;
      pend_q  <= 1'b0;
      irq_o   <= 1'b0;
      hit_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      pend_q  <= pend_d;
      irq_o   <= irq_d;
      hit_o   <= hit;
      rdata_o <= rdata_d;
    end
  end
endmodule

// File: tb/tb_timer_irq.sv
// tb_timer_irq: randomized and directed stimulus against a register-level timer model with a scoreboard
module tb_timer_irq;
  localparam logic [31:0] BASE = 32'h0000_2000;
  logic clk = 0, rst = 1, we = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic hit, irq;
  int checks = 0, errors = 0;
  typedef struct { logic [31:0] rd; logic hit; logic irq; int id; } exp_t;
  exp_t sbq[$];
  int cyc_id = 0;
  // reference model state: the architectural registers plus the prescale phase
  logic [2:0]  m_ctrl;
  int unsigned m_presc, m_count, m_cmp, m_pcnt;
  bit          m_pend;

  timer_irq dut (.clk_i(clk), .rst_i(rst), .addr_i(addr), .wdata_i(wdata), .we_i(we),
                 .rdata_o(rdata), .hit_o(hit), .irq_o(irq));

  always #5 clk = ~clk;

  function automatic int unsigned reg_val(input int o);
    case (o)
      0: return {29'd0, m_ctrl};
      1: return m_presc;
      2: return m_count;
      3: return m_cmp;
      4: return {31'd0, m_pend};
      default: return 0;
    endcase
  endfunction

  task automatic cyc(input bit r, input logic [31:0] a, input logic [31:0] d, input bit w);
    exp_t e;
    bit in_win, tick, matched;
    int o;
    rst = r; addr = a; wdata = d; we = w;
    in_win = (a >> 5) == (BASE >> 5);
    o = int'(a[4:2]);
    if (r) begin
      e = '{0, 0, 0, cyc_id};
      m_ctrl = 0; m_presc = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF; m_pend = 0; m_pcnt = 0;
    end else begin
      e = '{in_win ? reg_val(o) : 0, in_win, m_pend & m_ctrl[1], cyc_id};
      tick = m_ctrl[0] && (m_pcnt == m_presc);
      matched = 0;
      if (m_ctrl[0]) m_pcnt = tick ? 0 : m_pcnt + 1;
      if (in_win && w && o == 2) m_count = d;
      else if (tick) begin
        matched = (m_count == m_cmp);
        m_count = (matched && m_ctrl[2]) ? 0 : m_count + 1;
      end
      if (in_win && w && o == 4 && d[0] && !matched) m_pend = 0;
      if (matched) m_pend = 1;
      if (in_win && w && o == 0) begin m_ctrl = d[2:0]; m_pcnt = 0; end
      if (in_win && w && o == 1) begin m_presc = d & 32'hFFFF; m_pcnt = 0; end
      if (in_win && w && o == 3) m_cmp = d;
    end
    @(posedge clk);
    #1;
    sbq.push_back(e);
    cyc_id++;
  endtask

  task automatic wr(input int o, input logic [31:0] d);
    cyc(0, BASE + 32'(o * 4), d, 1);
  endtask

  task automatic rd(input int o, input int n);
    for (int i = 0; i < n; i++) cyc(0, BASE + 32'(o * 4), 0, 0);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if (rdata !== e.rd || hit !== e.hit || irq !== e.irq) begin
        errors++;
        $display("FAIL cycle%0d: rdata=%h hit=%b irq=%b, expected rdata=%h hit=%b irq=%b",
                 e.id, rdata, hit, irq, e.rd, e.hit, e.irq);
      end
    end
  end

  initial begin
    int o;
    logic [31:0] d;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) rd(i, 1);
    cyc(0, BASE + 32'h20, 0, 0);
    cyc(0, BASE + 32'h20, 0, 0);
    // one-shot compare
    wr(1, 0); wr(3, 5); wr(0, 3);
    rd(2, 6); rd(4, 4); rd(2, 3);
    wr(4, 1); rd(4, 3);
    // periodic, prescaled by 4
    cyc(1, 0, 0, 0);
    wr(1, 3); wr(3, 2); wr(0, 7);
    rd(2, 20); rd(4, 2); wr(4, 1); rd(2, 16);
    // COUNT write colliding with a tick
    cyc(1, 0, 0, 0);
    wr(1, 0); wr(0, 1);
    wr(2, 32'h1234); wr(2, 32'h77); rd(2, 2);
    // W1C colliding with a match
    wr(3, 10); wr(2, 8); rd(2, 2); wr(4, 1); rd(4, 2); wr(4, 1); rd(4, 2);
    // wrap and freeze
    wr(3, 32'h10); wr(2, 32'hFFFF_FFFF); rd(2, 3);
    wr(0, 0); rd(2, 10); wr(0, 1); rd(2, 3);
    // reset mid-count
    cyc(1, BASE + 8, 0, 0);
    for (int i = 0; i < 5; i++) rd(i, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      o = $urandom_range(0, 7);
      d = (o == 1) ? 32'($urandom_range(0, 3)) :
          (o == 2 || o == 3) ? 32'($urandom_range(0, 20)) : $urandom;
      if ($urandom_range(0, 49) == 0) cyc(1, BASE, 0, 0);
      else if ($urandom_range(0, 9) == 0) cyc(0, $urandom, d, 1'($urandom));
      else cyc(0, BASE + 32'(o * 4) + 32'($urandom_range(0, 3)), d, $urandom_range(0, 3) == 0);
    end
    cyc(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
